// File: rtl/char_fb_pkg.sv
// Shared constants, types and address helper for the character frame-buffer write path.
package char_fb_pkg;

  localparam int COLS      = 40;
  localparam int ROWS      = 30;
  localparam int FB_CELLS  = COLS * ROWS;
  localparam int FB_ADDR_W = 11;
  localparam int CHAR_W    = 5;

  typedef logic [CHAR_W-1:0]    char_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } sched_state_t;

  // Linear cell address y*cols + x, computed at the full address width so
  // in-range coordinates never truncate.
  function automatic fb_addr_t cell_addr(input logic [5:0] x, input logic [5:0] y, input int cols);
    return fb_addr_t'(y) * fb_addr_t'(cols) + fb_addr_t'(x);
  endfunction

endpackage

// File: rtl/char_write_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer upward with wrap.
// The pointer moves past the granted requester; it holds when nothing is granted.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] ptr_next_s;
  logic [PW-1:0] idx_s;
  logic          hit_s;
  logic          found_s;

  // Scan requesters starting at the pointer; first valid one wins.
  always_comb begin
    grant      = {N{1'b0}};
    found_s    = 1'b0;
    hit_s      = 1'b0;
    idx_s      = {PW{1'b0}};
    ptr_next_s = ptr_r;
    for (int k = 0; k < N; k++) begin
      idx_s        = PW'((int'(ptr_r) + k) % N);
      hit_s        = enable & req[idx_s] & ~found_s;
      grant[idx_s] = hit_s;
      found_s      = found_s | hit_s;
      ptr_next_s   = hit_s ? PW'((int'(idx_s) + 1) % N) : ptr_next_s;
    end
  end

  // Pointer advances only on a grant (a grant is always an accept).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r <= {PW{1'b0}};
    end else if (found_s) begin
      ptr_r <= ptr_next_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/char_write_scheduler.sv
// Shares the frame-buffer write port among NREQ requesters and sequences a
// full-screen clear. Writes are issued only while wr_allow is high.
module char_write_scheduler
  import char_fb_pkg::*;
#(
  parameter int                NREQ       = 4,
  parameter int                COLS       = 40,
  parameter int                ROWS       = 30,
  parameter int                CHAR_W     = 5,
  parameter logic [CHAR_W-1:0] BLANK_CHAR = {CHAR_W{1'b0}}
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*6-1:0]      req_x,
  input  logic [NREQ*6-1:0]      req_y,
  input  logic [NREQ*CHAR_W-1:0] req_char,
  input  logic                   clear_req,
  output logic                   clear_busy,
  input  logic                   wr_allow,
  output logic                   wr_en,
  output fb_addr_t               wr_addr,
  output logic [CHAR_W-1:0]      wr_char,
  output logic                   err_oob
);

  localparam int LAST_CELL = COLS * ROWS - 1;

  sched_state_t      state_r;
  fb_addr_t          cnt_r;
  logic              arb_en_s;
  logic              accept_s;
  logic              oob_s;
  logic [5:0]        sel_x_s;
  logic [5:0]        sel_y_s;
  logic [CHAR_W-1:0] sel_char_s;
  fb_addr_t          sel_addr_s;

  // Grants only in IDLE with the write window open; a clear request pre-empts.
  always_comb begin
    arb_en_s = (state_r == IDLE) & wr_allow & ~clear_req;
  end

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_valid),
    .enable  (arb_en_s),
    .grant   (req_ready)
  );

  // One-hot mux of the granted request, range check and address computation.
  always_comb begin
    sel_x_s    = 6'd0;
    sel_y_s    = 6'd0;
    sel_char_s = {CHAR_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      sel_x_s    = sel_x_s    | ({6{req_ready[i]}}      & req_x[6*i +: 6]);
      sel_y_s    = sel_y_s    | ({6{req_ready[i]}}      & req_y[6*i +: 6]);
      sel_char_s = sel_char_s | ({CHAR_W{req_ready[i]}} & req_char[CHAR_W*i +: CHAR_W]);
    end
    accept_s   = |req_ready;
    oob_s      = (int'(sel_x_s) >= COLS) | (int'(sel_y_s) >= ROWS);
    sel_addr_s = cell_addr(sel_x_s, sel_y_s, COLS);
  end

  // Scheduler FSM with registered write port, clear counter and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cnt_r      <= {FB_ADDR_W{1'b0}};
      wr_en      <= 1'b0;
      wr_addr    <= {FB_ADDR_W{1'b0}};
      wr_char    <= {CHAR_W{1'b0}};
      clear_busy <= 1'b0;
      err_oob    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= {FB_ADDR_W{1'b0}};
          if (clear_req) begin
            state_r    <= CLEAR;
            clear_busy <= 1'b1;
            wr_en      <= 1'b0;
            err_oob    <= 1'b0;
          end else if (accept_s) begin
            // Out-of-range requests are consumed but only flagged, never written.
            wr_en   <= ~oob_s;
            err_oob <= oob_s;
            if (!oob_s) begin
              wr_addr <= sel_addr_s;
              wr_char <= sel_char_s;
            end else begin
              wr_addr <= wr_addr;
              wr_char <= wr_char;
            end
          end else begin
            wr_en   <= 1'b0;
            err_oob <= 1'b0;
          end
        end
        CLEAR: begin
          err_oob <= 1'b0;
          if (wr_allow) begin
            wr_en   <= 1'b1;
            wr_addr <= cnt_r;
            wr_char <= BLANK_CHAR;
            if (cnt_r == fb_addr_t'(LAST_CELL)) begin
              cnt_r      <= {FB_ADDR_W{1'b0}};
              state_r    <= IDLE;
              clear_busy <= 1'b0;
            end else begin
              cnt_r <= cnt_r + 11'd1;
            end
          end else begin
            // Window closed: the walk pauses on the current cell.
            wr_en <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= {FB_ADDR_W{1'b0}};
          wr_en      <= 1'b0;
          clear_busy <= 1'b0;
          err_oob    <= 1'b0;
        end
      endcase
    end
  end

endmodule
